sysid_checker: RTL and testbench
================================

SYSID_CHECKER -- requirements
Module: sysid_checker

Interface
REQ-001 SHALL have parameter EXPECTED_ID, default 18, the 32-bit system ID value the design expects.
REQ-002 SHALL have parameter EXPECTED_TIMESTAMP, default 1366147204, the 32-bit build timestamp the design expects.
REQ-003 SHALL have parameter READ_LATENCY, default 0, range 0..3: cycles from read acceptance to valid avm_readdata.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, range 1..65535: maximum waitrequest stall per read.
REQ-005 SHALL have parameter AUTO_START, default 1: when 1, run one check automatically after reset release.
REQ-006 SHALL have port clock, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port start, input, 1 bit: single-cycle request to run a check.
REQ-009 SHALL have port avm_address, output, 1 bit: 0 selects the ID word, 1 selects the timestamp word.
REQ-010 SHALL have port avm_read, output, 1 bit: Avalon-MM read request.
REQ-011 SHALL have port avm_waitrequest, input, 1 bit: the slave stalls acceptance while high.
REQ-012 SHALL have port avm_readdata, input, 32 bits: read data from the system ID slave.
REQ-013 SHALL have port busy, output, 1 bit: a check is in progress.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse when a check completes.
REQ-015 SHALL have ports id_match and ts_match, output, 1 bit each: result of the last check.
REQ-016 SHALL have ports id_value and ts_value, output, 32 bits each: words captured by the last check.
REQ-017 SHALL have port timeout, output, 1 bit: the last check aborted on a stall.
REQ-018 SHALL have port mismatch_count, output, 8 bits: number of failed checks since reset.

Function
REQ-019 SHALL implement FSM states IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS and FIN.
REQ-020 SHALL move IDLE->RD_ID on start=1, or on the first cycle after reset release when AUTO_START=1.
REQ-021 SHALL, in RD_ID and RD_TS, assert avm_read=1 with avm_address 0 or 1 respectively, held stable until avm_waitrequest=0.
REQ-022 SHALL treat a read as accepted in the cycle where avm_read=1 and avm_waitrequest=0.
REQ-023 SHALL deassert avm_read in the cycle after acceptance; there is never more than one outstanding read.
REQ-024 SHALL, with READ_LATENCY=0, capture avm_readdata in the acceptance cycle and skip the LAT_ state.
REQ-025 SHALL, with READ_LATENCY=N>0, count N cycles in the LAT_ state and capture on the Nth cycle.
REQ-026 SHALL sequence RD_ID->(LAT_ID)->RD_TS->(LAT_TS)->FIN->IDLE.
REQ-027 SHALL, in FIN, pulse done for exactly 1 cycle and update id_match, ts_match and timeout together.
REQ-028 SHALL keep busy=1 in every state except IDLE.
REQ-029 SHALL ignore start while busy=1; no request is queued.
REQ-030 SHALL reset the stall counter on each new read and, if it reaches TIMEOUT_CYCLES, drop avm_read and go to FIN with timeout=1, id_match=0 and ts_match=0.
REQ-031 SHALL increment mismatch_count in FIN when timeout=1 or either match is 0, saturating at 255.
REQ-032 SHALL hold id_value, ts_value and all match flags unchanged until the next FIN.

Reset
REQ-033 SHALL, on reset_n=0, immediately force: state IDLE, avm_read=0, avm_address=0, busy=0, done=0, id_match=0, ts_match=0, timeout=0, id_value=0, ts_value=0, mismatch_count=0, and all counters 0.
REQ-034 SHALL abandon any in-flight read on reset, with no done pulse.

Structure
REQ-035 SHALL place the FSM state enumeration and the widths of the latency and stall counters in a shared package, sysid_pkg.
REQ-036 SHALL be a single module with no sub-modules; the stall counter is inline.

Verification
REQ-037 Reset release, AUTO_START=1, slave returns 18 / 1366147204, waitrequest=0 -> done pulses by cycle 4; id_match=1, ts_match=1, mismatch_count=0.
REQ-038 READ_LATENCY=2, slave timestamp 0x00000000 -> ts_match=0, id_match=1, mismatch_count=1, ts_value=0.
REQ-039 waitrequest high for 10 cycles on the ID read -> avm_read and avm_address=0 stable for all 11 cycles; check passes.
REQ-040 TIMEOUT_CYCLES=4, waitrequest held high -> avm_read drops after 4 cycles; timeout=1, done pulses once, mismatch_count increments.
REQ-041 start pulsed while busy, then reset_n=0 during LAT_TS -> only one check runs; reset immediately zeroes all outputs with no done pulse.
REQ-042 300 forced-mismatch checks -> mismatch_count saturates at 255.

Source files
------------

// File: rtl/sysid_pkg.sv
// Shared types and counter widths for the system-ID checker.
package sysid_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RD_ID  = 3'd1,
      S_LAT_ID = 3'd2,
      S_RD_TS  = 3'd3,
      S_LAT_TS = 3'd4,
      S_FIN    = 3'd5
   } sysid_state_e;

   localparam int LAT_CNT_W   = 2;
   localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/sysid_checker.sv
// Reads the ID and timestamp words from a system-ID slave over Avalon-MM and
// compares them with the build-time values, with stall timeout and fail counting.
module sysid_checker
   import sysid_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID        = 32'd18,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1366147204,
   parameter int          READ_LATENCY       = 0,
   parameter int          TIMEOUT_CYCLES     = 255,
   parameter int          AUTO_START         = 1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   output logic        busy,
   output logic        done,
   output logic        id_match,
   output logic        ts_match,
   output logic [31:0] id_value,
   output logic [31:0] ts_value,
   output logic        timeout,
   output logic [7:0]  mismatch_count
);

   localparam logic [LAT_CNT_W-1:0]   LAT_LAST   =
      LAT_CNT_W'((READ_LATENCY == 0) ? 0 : READ_LATENCY - 1);
   localparam logic [STALL_CNT_W-1:0] STALL_LAST = STALL_CNT_W'(TIMEOUT_CYCLES - 1);

   sysid_state_e           state_q;
   logic                   avm_read_q;
   logic                   avm_addr_q;
   logic                   busy_q;
   logic                   done_q;
   logic                   id_match_q;
   logic                   ts_match_q;
   logic                   timeout_q;
   logic [31:0]            id_value_q;
   logic [31:0]            ts_value_q;
   logic [31:0]            id_cap_q;
   logic [7:0]             mcount_q;
   logic [7:0]             mcount_d;
   logic [LAT_CNT_W-1:0]   lat_q;
   logic [STALL_CNT_W-1:0] stall_q;
   logic                   auto_q;
   logic                   accept_s;
   logic                   stall_hit_s;
   logic                   ts_done_s;
   logic                   fail_s;

   // Acceptance, timeout and completion conditions for the current cycle
   always_comb begin
      accept_s    = avm_read_q & ~avm_waitrequest;
      stall_hit_s = avm_read_q & avm_waitrequest & (stall_q == STALL_LAST);
      if (READ_LATENCY == 0) begin
         ts_done_s = (state_q == S_RD_TS) & accept_s;
      end else begin
         ts_done_s = (state_q == S_LAT_TS) & (lat_q == LAT_LAST);
      end
      fail_s   = stall_hit_s | (id_cap_q != EXPECTED_ID) | (avm_readdata != EXPECTED_TIMESTAMP);
      mcount_d = (mcount_q == 8'hFF) ? mcount_q : mcount_q + 8'd1;
   end

   // Check sequencer with registered bus and result outputs
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         avm_read_q <= 1'b0;
         avm_addr_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         id_match_q <= 1'b0;
         ts_match_q <= 1'b0;
         timeout_q  <= 1'b0;
         id_value_q <= 32'd0;
         ts_value_q <= 32'd0;
         id_cap_q   <= 32'd0;
         mcount_q   <= 8'd0;
         lat_q      <= '0;
         stall_q    <= '0;
         auto_q     <= (AUTO_START != 0);
      end else begin
         done_q <= 1'b0;
         auto_q <= 1'b0;
         // A stall timeout or the final timestamp capture both land in FIN
         if (stall_hit_s || ts_done_s) begin
            state_q    <= S_FIN;
            avm_read_q <= 1'b0;
            done_q     <= 1'b1;
            timeout_q  <= stall_hit_s;
            id_value_q <= id_cap_q;
            ts_value_q <= stall_hit_s ? 32'd0 : avm_readdata;
            id_match_q <= ~stall_hit_s & (id_cap_q == EXPECTED_ID);
            ts_match_q <= ~stall_hit_s & (avm_readdata == EXPECTED_TIMESTAMP);
            if (fail_s) begin
               mcount_q <= mcount_d;
            end else begin
               mcount_q <= mcount_q;
            end
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (start || auto_q) begin
                     state_q    <= S_RD_ID;
                     busy_q     <= 1'b1;
                     avm_read_q <= 1'b1;
                     avm_addr_q <= 1'b0;
                     stall_q    <= '0;
                     id_cap_q   <= 32'd0;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
               S_RD_ID: begin
                  if (accept_s) begin
                     avm_read_q <= 1'b0;
                     lat_q      <= '0;
                     if (READ_LATENCY == 0) begin
                        id_cap_q <= avm_readdata;
                        state_q  <= S_RD_TS;
                     end else begin
                        state_q <= S_LAT_ID;
                     end
                  end else begin
                     stall_q <= stall_q + STALL_CNT_W'(1);
                  end
               end
               S_LAT_ID: begin
                  if (lat_q == LAT_LAST) begin
                     id_cap_q <= avm_readdata;
                     state_q  <= S_RD_TS;
                  end else begin
                     lat_q <= lat_q + LAT_CNT_W'(1);
                  end
               end
               // First cycle here is the idle gap after the ID read; then issue
               S_RD_TS: begin
                  if (!avm_read_q) begin
                     avm_read_q <= 1'b1;
                     avm_addr_q <= 1'b1;
                     stall_q    <= '0;
                  end else if (accept_s) begin
                     avm_read_q <= 1'b0;
                     lat_q      <= '0;
                     state_q    <= S_LAT_TS;
                  end else begin
                     stall_q <= stall_q + STALL_CNT_W'(1);
                  end
               end
               S_LAT_TS: begin
                  lat_q <= lat_q + LAT_CNT_W'(1);
               end
               S_FIN: begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
               default: begin
                  state_q    <= S_IDLE;
                  busy_q     <= 1'b0;
                  avm_read_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign avm_read       = avm_read_q;
   assign avm_address    = avm_addr_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign id_match       = id_match_q;
   assign ts_match       = ts_match_q;
   assign timeout        = timeout_q;
   assign id_value       = id_value_q;
   assign ts_value       = ts_value_q;
   assign mismatch_count = mcount_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench: instance 0 uses defaults (latency 0, auto start), instance 1
// uses latency 2, timeout 4 and manual start; each has its own slave model.
module tb_sysid_checker;

   localparam logic [31:0] GOOD_ID = 32'd18;
   localparam logic [31:0] GOOD_TS = 32'd1366147204;

   logic             clock;
   logic             reset_n;
   logic [1:0]       start;
   logic [1:0]       avm_address;
   logic [1:0]       avm_read;
   logic [1:0]       avm_waitrequest;
   logic [1:0]       busy;
   logic [1:0]       done;
   logic [1:0]       id_match;
   logic [1:0]       ts_match;
   logic [1:0]       timeout;
   logic [1:0][31:0] id_value;
   logic [1:0][31:0] ts_value;
   logic [1:0][7:0]  mcount;
   logic [31:0]      s_id [2];
   logic [31:0]      s_ts [2];

   int total = 0;
   int bad   = 0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int LAT = (g == 0) ? 0 : 2;
      logic [31:0] rdata;
      int          rem   = 0;
      logic        paddr = 1'b0;

      sysid_checker #(
         .EXPECTED_ID       (GOOD_ID),
         .EXPECTED_TIMESTAMP(GOOD_TS),
         .READ_LATENCY      (LAT),
         .TIMEOUT_CYCLES    ((g == 0) ? 255 : 4),
         .AUTO_START        ((g == 0) ? 1 : 0)
      ) u_dut (
         .clock          (clock),
         .reset_n        (reset_n),
         .start          (start[g]),
         .avm_address    (avm_address[g]),
         .avm_read       (avm_read[g]),
         .avm_waitrequest(avm_waitrequest[g]),
         .avm_readdata   (rdata),
         .busy           (busy[g]),
         .done           (done[g]),
         .id_match       (id_match[g]),
         .ts_match       (ts_match[g]),
         .id_value       (id_value[g]),
         .ts_value       (ts_value[g]),
         .timeout        (timeout[g]),
         .mismatch_count (mcount[g])
      );

      // Slave: data is valid only in the exact cycle the latency dictates
      always @(posedge clock) begin
         if (avm_read[g] && !avm_waitrequest[g]) begin
            rem   <= LAT;
            paddr <= avm_address[g];
         end else if (rem > 0) begin
            rem <= rem - 1;
         end
      end

      always_comb begin
         if (LAT == 0) begin
            rdata = (avm_read[g] && !avm_waitrequest[g]) ?
                    (avm_address[g] ? s_ts[g] : s_id[g]) : 32'hDEADBEEF;
         end else begin
            rdata = (rem == 1) ? (paddr ? s_ts[g] : s_id[g]) : 32'hDEADBEEF;
         end
      end
   end

   task automatic pulse_start(input int g);
      @(negedge clock);
      start[g] = 1'b1;
      @(negedge clock);
      start[g] = 1'b0;
   endtask

   task automatic wait_done(input int g, input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clock);
         if (done[g]) seen = 1'b1;
      end
   endtask

   task automatic test_reset;
      for (int g = 0; g < 2; g++) begin
         total++;
         if ({avm_read[g], avm_address[g], busy[g], done[g], id_match[g], ts_match[g], timeout[g]} !== 7'd0) begin
            bad++;
            $display("FAIL reset_ctrl[%0d]: got %b want 0000000", g,
                     {avm_read[g], avm_address[g], busy[g], done[g], id_match[g], ts_match[g], timeout[g]});
         end
         total++;
         if (id_value[g] !== 32'd0) begin
            bad++; $display("FAIL reset_id_value[%0d]: got %h want 0", g, id_value[g]);
         end
         total++;
         if (ts_value[g] !== 32'd0) begin
            bad++; $display("FAIL reset_ts_value[%0d]: got %h want 0", g, ts_value[g]);
         end
         total++;
         if (mcount[g] !== 8'd0) begin
            bad++; $display("FAIL reset_mcount[%0d]: got %0d want 0", g, mcount[g]);
         end
      end
   endtask

   task automatic test_auto_start;
      int first  = 0;
      int pulses = 0;
      s_id[0] = GOOD_ID;
      s_ts[0] = GOOD_TS;
      @(negedge clock);
      reset_n = 1'b1;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         @(negedge clock);
         if (done[0]) begin
            pulses++;
            if (first == 0) first = cyc;
         end
      end
      total++;
      if (first < 1 || first > 4) begin
         bad++; $display("FAIL auto_done_cycle: got %0d want 1..4", first);
      end
      total++;
      if (pulses != 1) begin
         bad++; $display("FAIL auto_done_pulses: got %0d want 1", pulses);
      end
      total++;
      if ({id_match[0], ts_match[0], timeout[0], busy[0]} !== 4'b1100) begin
         bad++; $display("FAIL auto_flags: got %b want 1100", {id_match[0], ts_match[0], timeout[0], busy[0]});
      end
      total++;
      if (id_value[0] !== GOOD_ID || ts_value[0] !== GOOD_TS) begin
         bad++; $display("FAIL auto_values: got %h/%h want %h/%h", id_value[0], ts_value[0], GOOD_ID, GOOD_TS);
      end
      total++;
      if (mcount[0] !== 8'd0) begin
         bad++; $display("FAIL auto_mcount: got %0d want 0", mcount[0]);
      end
   endtask

   task automatic test_latency;
      bit seen;
      s_id[1] = GOOD_ID;
      s_ts[1] = 32'h0000_0000;
      pulse_start(1);
      wait_done(1, 40, seen);
      total++;
      if (!seen) begin
         bad++; $display("FAIL lat_done: got no done want done within 40 cycles");
      end
      total++;
      if ({id_match[1], ts_match[1], timeout[1]} !== 3'b100) begin
         bad++; $display("FAIL lat_flags: got %b want 100", {id_match[1], ts_match[1], timeout[1]});
      end
      total++;
      if (id_value[1] !== GOOD_ID || ts_value[1] !== 32'd0) begin
         bad++; $display("FAIL lat_values: got %h/%h want %h/0", id_value[1], ts_value[1], GOOD_ID);
      end
      total++;
      if (mcount[1] !== 8'd1) begin
         bad++; $display("FAIL lat_mcount: got %0d want 1", mcount[1]);
      end
   endtask

   task automatic test_stall;
      bit seen;
      int unstable = 0;
      avm_waitrequest[0] = 1'b1;
      pulse_start(0);
      for (int i = 0; i <= 10; i++) begin
         if (i > 0) @(negedge clock);
         if (avm_read[0] !== 1'b1 || avm_address[0] !== 1'b0) unstable++;
         if (i == 10) avm_waitrequest[0] = 1'b0;
      end
      total++;
      if (unstable != 0) begin
         bad++; $display("FAIL stall_stable: got %0d unstable cycles want 0", unstable);
      end
      wait_done(0, 20, seen);
      total++;
      if (!seen || {id_match[0], ts_match[0], timeout[0]} !== 3'b110) begin
         bad++; $display("FAIL stall_result: got done=%0d flags=%b want done=1 flags=110", seen,
                         {id_match[0], ts_match[0], timeout[0]});
      end
      total++;
      if (mcount[0] !== 8'd0) begin
         bad++; $display("FAIL stall_mcount: got %0d want 0", mcount[0]);
      end
   endtask

   task automatic test_timeout;
      int rd_cycles = 0;
      int pulses    = 0;
      avm_waitrequest[1] = 1'b1;
      pulse_start(1);
      for (int i = 0; i < 16; i++) begin
         if (i > 0) @(negedge clock);
         if (avm_read[1]) rd_cycles++;
         if (done[1]) pulses++;
      end
      avm_waitrequest[1] = 1'b0;
      total++;
      if (rd_cycles != 4) begin
         bad++; $display("FAIL to_read_cycles: got %0d want 4", rd_cycles);
      end
      total++;
      if (pulses != 1) begin
         bad++; $display("FAIL to_done_pulses: got %0d want 1", pulses);
      end
      total++;
      if ({id_match[1], ts_match[1], timeout[1]} !== 3'b001) begin
         bad++; $display("FAIL to_flags: got %b want 001", {id_match[1], ts_match[1], timeout[1]});
      end
      total++;
      if (mcount[1] !== 8'd2) begin
         bad++; $display("FAIL to_mcount: got %0d want 2", mcount[1]);
      end
   endtask

   task automatic test_busy_reset;
      int  pulses = 0;
      bit  found  = 1'b0;
      int  spur   = 0;
      s_ts[1] = GOOD_TS;
      pulse_start(1);
      if (done[1]) pulses++;
      @(negedge clock);
      if (done[1]) pulses++;
      pulse_start(1);
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (done[1]) pulses++;
      end
      total++;
      if (pulses != 1) begin
         bad++; $display("FAIL busy_ignore_pulses: got %0d want 1", pulses);
      end
      total++;
      if ({id_match[1], ts_match[1], timeout[1]} !== 3'b110 || mcount[1] !== 8'd2) begin
         bad++; $display("FAIL busy_result: got %b mc=%0d want 110 mc=2",
                         {id_match[1], ts_match[1], timeout[1]}, mcount[1]);
      end
      pulse_start(1);
      for (int i = 0; i < 30 && !found; i++) begin
         @(negedge clock);
         if (avm_read[1] && avm_address[1]) found = 1'b1;
      end
      total++;
      if (!found) begin
         bad++; $display("FAIL busy_ts_read: got no timestamp read want one within 30 cycles");
      end
      @(posedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      total++;
      if ({avm_read[1], avm_address[1], busy[1], done[1], id_match[1], ts_match[1], timeout[1]} !== 7'd0 ||
          id_value[1] !== 32'd0 || ts_value[1] !== 32'd0 || mcount[1] !== 8'd0) begin
         bad++; $display("FAIL async_reset: got ctrl=%b id=%h ts=%h mc=%0d want all 0",
                         {avm_read[1], avm_address[1], busy[1], done[1], id_match[1], ts_match[1], timeout[1]},
                         id_value[1], ts_value[1], mcount[1]);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         if (done !== 2'b00) spur++;
      end
      total++;
      if (spur != 0) begin
         bad++; $display("FAIL reset_no_done: got %0d done cycles want 0", spur);
      end
   endtask

   task automatic test_saturation;
      bit seen;
      int missed = 0;
      s_id[0] = GOOD_ID;
      reset_n = 1'b1;
      wait_done(0, 12, seen);
      @(negedge clock);
      s_id[0] = 32'd99;
      for (int k = 1; k <= 300; k++) begin
         pulse_start(0);
         wait_done(0, 30, seen);
         if (!seen) missed++;
         if (k == 10 || k == 254 || k == 255) begin
            total++;
            if (mcount[0] !== 8'(k)) begin
               bad++; $display("FAIL sat_mcount_at_%0d: got %0d want %0d", k, mcount[0], k);
            end
         end
      end
      total++;
      if (missed != 0) begin
         bad++; $display("FAIL sat_done: got %0d missing done want 0", missed);
      end
      total++;
      if (mcount[0] !== 8'd255 || id_match[0] !== 1'b0) begin
         bad++; $display("FAIL sat_final: got mc=%0d idm=%0d want mc=255 idm=0", mcount[0], id_match[0]);
      end
   endtask

   initial begin
      reset_n         = 1'b0;
      start           = 2'b00;
      avm_waitrequest = 2'b00;
      s_id[0] = GOOD_ID; s_ts[0] = GOOD_TS;
      s_id[1] = GOOD_ID; s_ts[1] = GOOD_TS;
      #12;
      test_reset();
      test_auto_start();
      test_latency();
      test_stall();
      test_timeout();
      test_busy_reset();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
